// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the TinyChip datapath: fetch, decode, execute,
// optional data-memory access, writeback, PC update and halt.
module core_sequencer #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  input  logic               dec_is_halt,
  input  logic               dec_is_mem,
  input  logic               dec_is_branch,
  input  logic               dec_writes_rf,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               dmem_req,
  input  logic               dmem_ack,
  output logic               rf_we,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               imem_req_q, dmem_req_q, rf_we_q, busy_q, done_q;
  logic               launch;

  assign launch = start && (state_q == S_IDLE || state_q == S_HALT);

  // Handshake: a request stays high from the cycle its state is entered until
  // an ack is sampled on a rising edge; acks seen with the request low are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = dec_is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = dec_is_mem ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      cnt_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM);
      rf_we_q    <= (state_d == S_WB) && dec_writes_rf;
      busy_q     <= !(state_d == S_IDLE || state_d == S_HALT);
      done_q     <= (state_d == S_HALT);
      if (state_q == S_FETCH && imem_ack) instr_q <= imem_rdata;
      if (launch) begin
        pc_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (busy_q && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        if (state_q == S_WB)
          pc_q <= (dec_is_branch && br_taken) ? br_target : pc_q + PC_W'(1);
      end
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign imem_req    = imem_req_q;
  assign dmem_req    = dmem_req_q;
  assign rf_we       = rf_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed programs, memory responders,
// and a monitor that checks fetch addresses, writebacks and halts.
module tb_core_sequencer;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  localparam logic [INSTR_W-1:0] I_ALU     = 9'b000_000001;
  localparam logic [INSTR_W-1:0] I_LOAD    = 9'b001_000010;
  localparam logic [INSTR_W-1:0] I_BR_T155 = 9'b011_100000;
  localparam logic [INSTR_W-1:0] I_BR_NT   = 9'b011_000000;
  localparam logic [INSTR_W-1:0] I_BR_T3FF = 9'b011_100001;
  localparam logic [INSTR_W-1:0] I_HALT    = 9'b111_000000;

  logic               clk = 1'b0;
  logic               reset, start;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_req, imem_ack;
  logic [INSTR_W-1:0] imem_rdata, instr;
  logic               dec_is_halt, dec_is_mem, dec_is_branch, dec_writes_rf;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               dmem_req, dmem_ack, rf_we, busy, done;
  logic [CNT_W-1:0]   cycle_count;
  logic [2:0]         dbg_state;

  logic [INSTR_W-1:0] mem [0:1023];
  int                 dmem_wait = 0;
  int                 pass_cnt = 0;
  int                 total_cnt = 0;
  logic               done_prev = 1'b0;
  logic [PC_W-1:0]    exp_fetch_q[$];
  logic [PC_W-1:0]    exp_rf_q[$];
  logic [PC_W-1:0]    exp_done_q[$];

  core_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr),
    .dec_is_halt(dec_is_halt), .dec_is_mem(dec_is_mem),
    .dec_is_branch(dec_is_branch), .dec_writes_rf(dec_writes_rf),
    .br_taken(br_taken), .br_target(br_target),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .busy(busy), .done(done),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // Toy decoder: opcode in the top 3 bits, branch taken bit 5, target select bit 0.
  logic [2:0] op;
  assign op            = instr[8:6];
  assign dec_is_halt   = (op == 3'd7);
  assign dec_is_mem    = (op == 3'd1) || (op == 3'd2);
  assign dec_is_branch = (op == 3'd3);
  assign dec_writes_rf = (op == 3'd0) || (op == 3'd1);
  assign br_taken      = instr[5];
  assign br_target     = instr[0] ? 10'h3FF : 10'h155;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_done(input int bound, input string name);
    for (int i = 0; i < bound && !done; i++) step();
    check(name, 32'(done), 32'd1);
  endtask

  // Instruction memory responder: zero-wait ack
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (imem_req) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
      end else begin
        imem_ack = 1'b0;
      end
    end
  end

  // Data memory responder: ack after dmem_wait cycles of request
  initial begin
    int dw;
    dw       = 0;
    dmem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dmem_req) begin
        if (dw >= dmem_wait) dmem_ack = 1'b1;
        else begin
          dmem_ack = 1'b0;
          dw++;
        end
      end else begin
        dmem_ack = 1'b0;
        dw       = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req && imem_ack) begin
        if (exp_fetch_q.size() == 0) check("fetch_unexpected", 32'(imem_addr), 32'hFFFF);
        else check("fetch_addr", 32'(imem_addr), 32'(exp_fetch_q.pop_front()));
      end
      if (rf_we) begin
        if (exp_rf_q.size() == 0) check("rf_we_unexpected", 32'(imem_addr), 32'hFFFF);
        else check("rf_we_pc", 32'(imem_addr), 32'(exp_rf_q.pop_front()));
      end
      if (done && !done_prev) begin
        if (exp_done_q.size() == 0) check("done_unexpected", 32'(imem_addr), 32'hFFFF);
        else check("halt_pc", 32'(imem_addr), 32'(exp_done_q.pop_front()));
      end
      done_prev = done;
    end
  end

  // Driver
  initial begin
    logic [4:0]       req_hist, rf_hist;
    logic [CNT_W-1:0] cnt0;
    int               dm_high, last_dm, rf_step;
    logic             found, rf_seen, addr_moved, cnt_moved, any_busy;

    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = I_ALU;

    // start while reset is low has no effect
    step(); step();
    start = 1'b1;
    step(); step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    step(); step();
    check("idle_no_start", 32'(busy), 32'd0);

    // Run A: ALU, load, taken branch, not-taken branch, halt
    mem[0]      = I_ALU;
    mem[1]      = I_LOAD;
    mem[2]      = I_BR_T155;
    mem[10'h155] = I_BR_NT;
    mem[10'h156] = I_HALT;
    dmem_wait   = 3;
    exp_fetch_q = '{10'h000, 10'h001, 10'h002, 10'h155, 10'h156};
    exp_rf_q    = '{10'h000, 10'h001};
    exp_done_q  = '{10'h156};
    start = 1'b1;
    step();
    start = 1'b0;
    check("a_first_addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 5; i++) begin
      req_hist[i] = imem_req;
      rf_hist[i]  = rf_we;
      if (i < 4) step();
    end
    check("a_imem_req_shape", 32'(req_hist), 32'h11);
    check("a_rf_we_shape", 32'(rf_hist), 32'h08);
    check("a_pc_after_alu", 32'(imem_addr), 32'd1);
    check("a_count_after_alu", 32'(cycle_count), 32'd4);

    cnt0    = cycle_count;
    dm_high = 0;
    last_dm = -1;
    rf_step = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (dmem_req) begin
        dm_high++;
        last_dm = i;
      end
      if (rf_we) rf_step = i;
    end
    check("a_dmem_req_len", 32'(dm_high), 32'd4);
    check("a_dmem_last", 32'(last_dm), 32'd6);
    check("a_load_wb_step", 32'(rf_step), 32'd7);
    check("a_load_count_delta", 32'(cycle_count - cnt0), 32'd8);
    check("a_pc_after_load", 32'(imem_addr), 32'd2);

    wait_done(100, "a_done_timeout");
    check("a_halt_busy", 32'(busy), 32'd0);
    check("a_halt_count", 32'(cycle_count), 32'd22);

    // Run B: branch to 0x3FF, wrap to 0, then ALUs up to halt at 5
    mem[0] = I_BR_T3FF;
    mem[1] = I_ALU;
    mem[2] = I_ALU;
    mem[5] = I_HALT;
    exp_fetch_q = '{10'h000, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
    exp_rf_q    = '{10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004};
    exp_done_q  = '{10'h005};
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_ack && imem_addr == 10'h3FF) found = 1'b1;
      else step();
    end
    check("b_fetch_3ff_seen", 32'(found), 32'd1);
    mem[0] = I_ALU;

    wait_done(100, "b_done_timeout");
    check("b_halt_busy", 32'(busy), 32'd0);
    check("b_halt_pc", 32'(imem_addr), 32'd5);
    check("b_halt_count", 32'(cycle_count), 32'd30);
    cnt0       = cycle_count;
    rf_seen    = 1'b0;
    addr_moved = 1'b0;
    cnt_moved  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rf_we) rf_seen = 1'b1;
      if (imem_addr != 10'd5) addr_moved = 1'b1;
      if (cycle_count != cnt0) cnt_moved = 1'b1;
    end
    check("b_halt_no_rf_we", 32'(rf_seen), 32'd0);
    check("b_halt_pc_hold", 32'(addr_moved), 32'd0);
    check("b_halt_count_frozen", 32'(cnt_moved), 32'd0);
    check("b_halt_done_hold", 32'(done), 32'd1);

    // Run C: restart from HALT, then reset during a long MEM wait
    mem[1]      = I_LOAD;
    dmem_wait   = 20;
    exp_fetch_q = '{10'h000, 10'h001};
    exp_rf_q    = '{10'h000};
    start = 1'b1;
    step();
    start = 1'b0;
    check("c_restart_pc", 32'(imem_addr), 32'd0);
    check("c_restart_count", 32'(cycle_count), 32'd0);
    check("c_restart_busy", 32'(busy), 32'd1);
    check("c_restart_done", 32'(done), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (dmem_req) found = 1'b1;
      else step();
    end
    check("c_mem_reached", 32'(found), 32'd1);
    step(); step();
    #2 reset = 1'b0;
    #1;
    check("c_async_dmem_req", 32'(dmem_req), 32'd0);
    check("c_async_busy", 32'(busy), 32'd0);
    check("c_async_count", 32'(cycle_count), 32'd0);
    check("c_async_pc", 32'(imem_addr), 32'd0);
    check("c_async_instr", 32'(instr), 32'd0);
    step();
    reset = 1'b1;
    any_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy || imem_req || dmem_req) any_busy = 1'b1;
    end
    check("c_idle_after_reset", 32'(any_busy), 32'd0);

    check("sb_fetch_drained", 32'(exp_fetch_q.size()), 32'd0);
    check("sb_rf_drained", 32'(exp_rf_q.size()), 32'd0);
    check("sb_done_drained", 32'(exp_done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences the TinyChip datapath: fetches each instruction over an instruction-memory handshake, steps it through decode/execute/memory/writeback, updates the program counter, and raises `done` on a halt instruction. It sits between the top-level `controller` wrapper and the datapath. It consumes decoder flags and the branch decision, and drives the memory request lines and the register-file write strobe.

## Interface
- `PC_W`, 10, program-counter width
- `INSTR_W`, 9, instruction width
- `CNT_W`, 16, cycle-counter width

- `clk`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  begin execution at PC 0; honoured only in IDLE or HALT
- `imem_addr`  output  PC_W  current PC
- `imem_req`  output  1  fetch request
- `imem_ack`  input  1  fetch complete; `imem_rdata` valid this cycle
- `imem_rdata`  input  INSTR_W  fetched instruction
- `instr`  output  INSTR_W  instruction register, drives the decoder
- `dec_is_halt`, `dec_is_mem`, `dec_is_branch`, `dec_writes_rf`  input  1 each  decoder flags for `instr`
- `br_taken`  input  1  branch condition result
- `br_target`  input  PC_W  branch destination
- `dmem_req`  output  1  data-memory request
- `dmem_ack`  input  1  data-memory access complete
- `rf_we`  output  1  one-cycle register-file write strobe
- `busy`  output  1  high in FETCH, DECODE, EXEC, MEM and WB
- `done`  output  1  high in HALT
- `cycle_count`  output  CNT_W  cycles spent busy since last start

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- IDLE: when `start`=1, the block clears PC and `cycle_count` and moves to FETCH.
- FETCH: `imem_req`=1 and is held until `imem_ack` is sampled high. On ack, `instr` is loaded from `imem_rdata` and the FSM moves to DECODE.
- DECODE: lasts one cycle. If `dec_is_halt`=1, go to HALT. Otherwise go to EXEC.
- EXEC: lasts one cycle. If `dec_is_mem`=1, go to MEM. Otherwise go to WB.
- MEM: `dmem_req`=1 and is held until `dmem_ack` is sampled high, then the FSM moves to WB.
- WB: lasts one cycle.
  - `rf_we` = `dec_writes_rf`.
  - If `dec_is_branch` and `br_taken` are both 1, PC loads `br_target`. Otherwise PC increments by 1.
  - Next state is FETCH.
- HALT: `done`=1 and PC holds its value. When `start`=1, clear PC and `cycle_count` and go to FETCH. `start` is ignored in all other states.
- PC increment wraps modulo 2^PC_W: PC = 2^PC_W−1 followed by a non-taken instruction gives PC = 0.
- `cycle_count`:
  - Increments by 1 on every clock edge where `busy`=1.
  - Saturates at 2^CNT_W−1; it never wraps.
  - Holds its value in IDLE and HALT.
- `imem_ack` or `dmem_ack` arriving while the matching request is low is ignored.
- Decoder flags and `br_*` inputs are sampled only in the states listed above; their values in other states are don't-care.

## Timing
- Reset values: state IDLE, PC 0, `instr` 0, `cycle_count` 0. All of `imem_req`, `dmem_req`, `rf_we`, `busy`, `done` are 0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge. Any in-flight request is dropped.
- Execution resumes only after reset is released and `start` is seen.
- All outputs are Moore outputs: registered state/PC decode, with no combinational path from any input.
- A request rises in the cycle the FSM enters FETCH or MEM.
- An ack sampled high on the same edge the request first appears completes the access. The minimum FETCH or MEM residency is therefore 1 cycle.
- Latency from entering FETCH to re-entering FETCH, with all acks zero-wait:
  - non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB)
  - memory instruction: 5 cycles
  - each wait cycle on an ack adds 1
- Halt: `done` rises 2 cycles after FETCH is entered, with a zero-wait fetch. Halt does not pass through WB, so there is no `rf_we` and no PC update.
- `start` and reset:
  - `start` with reset low has no effect.
  - `start` held high across HALT restarts every time HALT is reached.

## Test plan
- Reset, then `start` pulse, with a zero-wait ALU instruction (`dec_writes_rf`=1) at PC 0 → `imem_addr` is 0. `rf_we` pulses exactly 1 cycle, 3 cycles after `imem_req` rises. PC becomes 1. `imem_req` returns 4 cycles after it first rose.
- Load instruction with `dmem_ack` delayed 3 cycles → `dmem_req` is high for 4 cycles. WB follows on the next cycle. `cycle_count` increases by 8 for that instruction.
- Taken branch with `br_target`=0x155 → next `imem_addr`=0x155. Same instruction with `br_taken`=0 → next `imem_addr` is PC+1.
- PC=0x3FF, non-branch instruction → next `imem_addr`=0x000.
- Halt at PC 5 → `done`=1 and `busy`=0. `imem_addr` stays 5, no `rf_we` pulses, `cycle_count` is frozen. A second `start` clears the count and fetches PC 0.
- Reset pulsed low in the middle of a MEM wait → `dmem_req`, `busy` and `cycle_count` drop to 0 before the next clock edge. After reset is released, the FSM stays in IDLE until `start`.
